// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD sector-link arbiter.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } sd_arb_state_t;

    localparam int   LBA_W           = 32;
    localparam int   BYTE_W          = 8;
    localparam int   MAX_REQ         = 4;
    localparam logic REQ_ERR_DEFAULT = 1'b0;

    // Round-robin successor of a client index, wrapping at num_req.
    function automatic logic [1:0] rr_next(input logic [1:0] idx, input int num_req);
        return (int'(idx) == num_req - 1) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/sd_arb_sync.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
module sd_arb_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sd_io_arbiter.sv
// Round-robin arbiter sharing one user_io SD sector link between NUM_REQ clients.
// Optional build macro SD_ARB_TIMEOUT_EN adds an ISSUE-state timeout abort that
// reports through req_err; without it ISSUE waits indefinitely for io_ack.
//
// state | meaning
// IDLE  | no grant; pick the next requester starting at rr_ptr
// ISSUE | io_rd/io_wr asserted, waiting for synchronised io_ack to rise
// XFER  | sector data moving; strobes routed to the granted client
// DONE  | req_done pulse to the granted client, advance rr_ptr, release grant
module sd_io_arbiter
    import sd_arb_pkg::*;
#(
    parameter int          NUM_REQ        = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_rd,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [LBA_W*NUM_REQ-1:0]  req_lba,
    input  logic [BYTE_W*NUM_REQ-1:0] req_dout,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [NUM_REQ-1:0]        req_din_strobe,
    output logic [NUM_REQ-1:0]        req_dout_strobe,
    output logic [LBA_W-1:0]          io_lba,
    output logic                      io_rd,
    output logic                      io_wr,
    input  logic                      io_ack,
    input  logic                      io_din_strobe,
    input  logic                      io_dout_strobe,
    output logic [BYTE_W-1:0]         io_dout
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES == 24'd0) begin : g_bad_param
        $error("sd_io_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES nonzero");
    end

    sd_arb_state_t       state, state_nxt;
    logic                grant_vld, grant_vld_nxt;
    logic [1:0]          grant_idx, grant_idx_nxt;
    logic [1:0]          rr_ptr, rr_ptr_nxt;
    logic [LBA_W-1:0]    lba_nxt;
    logic                rd_nxt, wr_nxt;
    logic                ack_s, ack_q, ack_rise, ack_fall;
    logic                win_vld;
    logic [1:0]          win_idx, cand;
    logic [NUM_REQ-1:0]  grant_oh;

    // Client inputs padded to MAX_REQ so a 2-bit index is always in range.
    logic [MAX_REQ-1:0]  rd_pad, wr_pad;
    logic [LBA_W-1:0]    lba_pad  [MAX_REQ];
    logic [BYTE_W-1:0]   dout_pad [MAX_REQ];

    for (genvar i = 0; i < MAX_REQ; i++) begin : g_pad
        if (i < NUM_REQ) begin : g_on
            assign rd_pad[i]   = req_rd[i];
            assign wr_pad[i]   = req_wr[i];
            assign lba_pad[i]  = req_lba[LBA_W*i +: LBA_W];
            assign dout_pad[i] = req_dout[BYTE_W*i +: BYTE_W];
        end else begin : g_off
            assign rd_pad[i]   = 1'b0;
            assign wr_pad[i]   = 1'b0;
            assign lba_pad[i]  = '0;
            assign dout_pad[i] = '0;
        end
    end

    sd_arb_sync u_ack_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (io_ack),
        .q       (ack_s)
    );

    // Edge-detect history for the synchronised acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ack_q <= 1'b0;
        else          ack_q <= ack_s;
    end

    assign ack_rise = ack_s & ~ack_q;
    assign ack_fall = ~ack_s & ack_q;

    // First requesting client at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        cand    = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = 2'((int'(rr_ptr) + k) % NUM_REQ);
            if (!win_vld && (rd_pad[cand] || wr_pad[cand])) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // One-hot view of the current grant; all zero while nobody holds the link.
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = grant_vld && (grant_idx == 2'(i));
        end
    end

    // Strobes reach only the granted client, so IDLE-time config uploads stay private.
    assign req_din_strobe  = grant_oh & {NUM_REQ{io_din_strobe}};
    assign req_dout_strobe = grant_oh & {NUM_REQ{io_dout_strobe}};
    assign io_dout         = grant_vld ? dout_pad[grant_idx] : {BYTE_W{1'b1}};
    assign req_done        = (state == DONE) ? grant_oh : '0;

`ifdef SD_ARB_TIMEOUT_EN
    localparam logic [23:0] TO_LOAD = TIMEOUT_CYCLES - 24'd1;

    logic [23:0] to_cnt;
    logic        to_hit;
    logic        err_q;

    // Down-counter reloaded outside ISSUE; terminal count aborts the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              to_cnt <= TO_LOAD;
        else if (state == ISSUE)   to_cnt <= to_cnt - 24'd1;
        else                       to_cnt <= TO_LOAD;
    end

    assign to_hit = (state == ISSUE) && (to_cnt == 24'd0);

    // Remember that the coming DONE is an abort rather than a normal completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)             err_q <= 1'b0;
        else if (state == ISSUE)  err_q <= to_hit & ~ack_rise;
        else if (state == DONE)   err_q <= 1'b0;
    end

    assign req_err = (state == DONE && err_q) ? grant_oh : {NUM_REQ{REQ_ERR_DEFAULT}};
`else
    assign req_err = {NUM_REQ{REQ_ERR_DEFAULT}};
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Grant, pointer and io request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_vld <= 1'b0;
            grant_idx <= 2'd0;
            rr_ptr    <= 2'd0;
            io_lba    <= '0;
            io_rd     <= 1'b0;
            io_wr     <= 1'b0;
        end else begin
            grant_vld <= grant_vld_nxt;
            grant_idx <= grant_idx_nxt;
            rr_ptr    <= rr_ptr_nxt;
            io_lba    <= lba_nxt;
            io_rd     <= rd_nxt;
            io_wr     <= wr_nxt;
        end
    end

    // Next-state and next-register logic; write wins when a client asks for both.
    always_comb begin
        state_nxt     = state;
        grant_vld_nxt = grant_vld;
        grant_idx_nxt = grant_idx;
        rr_ptr_nxt    = rr_ptr;
        lba_nxt       = io_lba;
        rd_nxt        = io_rd;
        wr_nxt        = io_wr;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    grant_vld_nxt = 1'b1;
                    grant_idx_nxt = win_idx;
                    lba_nxt       = lba_pad[win_idx];
                    wr_nxt        = wr_pad[win_idx];
                    rd_nxt        = rd_pad[win_idx] & ~wr_pad[win_idx];
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (ack_rise) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    state_nxt = XFER;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    state_nxt = DONE;
                end
`endif
            end
            XFER: begin
                if (ack_fall) state_nxt = DONE;
            end
            DONE: begin
                grant_vld_nxt = 1'b0;
                rr_ptr_nxt    = rr_next(grant_idx, NUM_REQ);
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sd_io_arbiter.sv
// Self-checking bench for sd_io_arbiter: directed scenarios plus randomized
// request traffic checked against a transaction-level round-robin model.
module tb_sd_io_arbiter;

    localparam int          N  = 3;
    localparam logic [23:0] TO = 24'd100;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_rd, req_wr;
    logic [32*N-1:0] req_lba;
    logic [8*N-1:0]  req_dout;
    logic [N-1:0]    req_done, req_err, req_din_strobe, req_dout_strobe;
    logic [31:0]     io_lba;
    logic            io_rd, io_wr;
    logic            io_ack, io_din_strobe, io_dout_strobe;
    logic [7:0]      io_dout;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: each client's request and the round-robin pointer.
    logic        m_rd   [N];
    logic        m_wr   [N];
    logic [31:0] m_lba  [N];
    logic [7:0]  m_dout [N];
    int          m_ptr;

    sd_io_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_rd          (req_rd),
        .req_wr          (req_wr),
        .req_lba         (req_lba),
        .req_dout        (req_dout),
        .req_done        (req_done),
        .req_err         (req_err),
        .req_din_strobe  (req_din_strobe),
        .req_dout_strobe (req_dout_strobe),
        .io_lba          (io_lba),
        .io_rd           (io_rd),
        .io_wr           (io_wr),
        .io_ack          (io_ack),
        .io_din_strobe   (io_din_strobe),
        .io_dout_strobe  (io_dout_strobe),
        .io_dout         (io_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [31:0] lba, input logic [7:0] d);
        m_rd[i] = rd;  m_wr[i] = wr;  m_lba[i] = lba;  m_dout[i] = d;
        req_rd[i] = rd;
        req_wr[i] = wr;
        req_lba[32*i +: 32] = lba;
        req_dout[8*i +: 8]  = d;
    endtask

    function automatic int next_winner();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (m_rd[j] || m_wr[j]) return j;
        end
        return -1;
    endfunction

    // Play user_io for one sector transaction expected to be granted to client w.
    task automatic run_txn(input int w, input int nstb, input bit keep,
                           input bit mid_change, input int ack_delay);
        int          n;
        logic [N-1:0] oh;
        logic        ew, er;
        logic [31:0] el;
        logic [7:0]  ed;
        oh = '0;
        oh[w] = 1'b1;
        ew = m_wr[w];
        er = m_rd[w] & ~m_wr[w];
        el = m_lba[w];
        ed = m_dout[w];

        n = 0;
        while (!(io_rd || io_wr) && n < 20) begin step(); n++; end
        check_eq("grant_wait", 32'(n < 20), 32'd1);
        check_eq("io_lba", io_lba, el);
        check_eq("io_wr", 32'(io_wr), 32'(ew));
        check_eq("io_rd", 32'(io_rd), 32'(er));
        check_eq("io_dout_granted", 32'(io_dout), 32'(ed));

        if (mid_change) begin
            req_rd[w] = 1'b0;
            req_wr[w] = 1'b0;
            req_lba[32*w +: 32] = ~el;
            m_rd[w] = 1'b0;
            m_wr[w] = 1'b0;
        end
        repeat (ack_delay) step();
        check_eq("io_req_held", 32'({io_rd, io_wr}), 32'({er, ew}));
        check_eq("io_lba_held", io_lba, el);

        io_ack = 1'b1;
        n = 0;
        while ((io_rd || io_wr) && n < 10) begin step(); n++; end
        check_eq("ack_rise_latency", 32'(n), 32'd3);

        for (int s = 0; s < nstb; s++) begin
            if (ew) begin
                ed = 8'($urandom);
                req_dout[8*w +: 8] = ed;
                m_dout[w] = ed;
                io_dout_strobe = 1'b1;
            end else begin
                io_din_strobe = 1'b1;
            end
            #1;
            check_eq("dout_strobe_route", 32'(req_dout_strobe), ew ? 32'(oh) : 32'd0);
            check_eq("din_strobe_route", 32'(req_din_strobe), ew ? 32'd0 : 32'(oh));
            check_eq("io_dout_xfer", 32'(io_dout), 32'(ed));
            step();
            io_dout_strobe = 1'b0;
            io_din_strobe  = 1'b0;
        end

        io_ack = 1'b0;
        n = 0;
        while (req_done == '0 && n < 10) begin step(); n++; end
        check_eq("done_latency", 32'(n), 32'd3);
        check_eq("req_done", 32'(req_done), 32'(oh));
        check_eq("req_err_normal", 32'(req_err), 32'd0);

        if (!keep) begin
            req_rd[w] = 1'b0;
            req_wr[w] = 1'b0;
            m_rd[w] = 1'b0;
            m_wr[w] = 1'b0;
        end
        m_ptr = (w + 1) % N;
        step();
        check_eq("done_pulse_end", 32'(req_done), 32'd0);
        check_eq("io_dout_idle", 32'(io_dout), 32'hFF);
    endtask

    initial begin
        int n;
        int w;
        reset_n = 1'b0;
        io_ack = 1'b0;
        io_din_strobe = 1'b0;
        io_dout_strobe = 1'b0;
        req_rd = '0;
        req_wr = '0;
        req_lba = '0;
        req_dout = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 32'd0, 8'd0);
        m_ptr = 0;

        // Reset values.
        repeat (3) step();
        check_eq("rst_io_rd", 32'(io_rd), 32'd0);
        check_eq("rst_io_lba", io_lba, 32'd0);
        reset_n = 1'b1;
        step();
        check_eq("rst_io_wr", 32'(io_wr), 32'd0);
        check_eq("rst_req_done", 32'(req_done), 32'd0);
        check_eq("rst_req_err", 32'(req_err), 32'd0);
        check_eq("rst_io_dout", 32'(io_dout), 32'hFF);

        // Strobes while IDLE must not reach any client.
        io_din_strobe = 1'b1;
        io_dout_strobe = 1'b1;
        #1;
        check_eq("idle_din_strobe", 32'(req_din_strobe), 32'd0);
        check_eq("idle_dout_strobe", 32'(req_dout_strobe), 32'd0);
        check_eq("idle_io_dout", 32'(io_dout), 32'hFF);
        step();
        io_din_strobe = 1'b0;
        io_dout_strobe = 1'b0;

        // Single read, one-clock request latency.
        set_req(0, 1'b1, 1'b0, 32'h1234, 8'hA5);
        step();
        check_eq("rd_latency", 32'(io_rd), 32'd1);
        run_txn(0, 4, 1'b0, 1'b0, 2);

        // Two clients requesting from reset release alternate 0,1,0,1.
        reset_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h0000_0100, 8'h11);
        set_req(1, 1'b1, 1'b0, 32'h0000_0200, 8'h22);
        m_ptr = 0;
        step();
        reset_n = 1'b1;
        run_txn(0, 2, 1'b1, 1'b0, 1);
        run_txn(1, 2, 1'b1, 1'b0, 1);
        run_txn(0, 2, 1'b0, 1'b0, 1);
        run_txn(1, 2, 1'b0, 1'b0, 1);

        // Read and write together: write wins, full 512-byte sector of strobes.
        set_req(1, 1'b1, 1'b1, 32'd7, 8'h5C);
        run_txn(1, 512, 1'b0, 1'b0, 1);

        // Reset during XFER abandons the transaction; pointer restarts at 0.
        set_req(1, 1'b1, 1'b0, 32'h0001_1111, 8'h31);
        run_txn(1, 2, 1'b0, 1'b0, 0);
        set_req(1, 1'b1, 1'b0, 32'h0001_2222, 8'h32);
        set_req(2, 1'b0, 1'b1, 32'h0002_3333, 8'h33);
        n = 0;
        while (!(io_rd || io_wr) && n < 20) begin step(); n++; end
        check_eq("pre_rst_grant_lba", io_lba, 32'h0002_3333);
        io_ack = 1'b1;
        n = 0;
        while ((io_rd || io_wr) && n < 10) begin step(); n++; end
        check_eq("pre_rst_xfer", 32'(n < 10), 32'd1);
        reset_n = 1'b0;
        io_din_strobe = 1'b1;
        #1;
        check_eq("rst_xfer_io_rd", 32'(io_rd), 32'd0);
        check_eq("rst_xfer_io_wr", 32'(io_wr), 32'd0);
        check_eq("rst_xfer_io_dout", 32'(io_dout), 32'hFF);
        check_eq("rst_xfer_strobe", 32'(req_din_strobe), 32'd0);
        check_eq("rst_xfer_lba", io_lba, 32'd0);
        io_din_strobe = 1'b0;
        io_ack = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        m_ptr = 0;
        run_txn(1, 2, 1'b0, 1'b0, 0);
        run_txn(2, 2, 1'b0, 1'b0, 0);

`ifdef SD_ARB_TIMEOUT_EN
        // No acknowledge: abort after TIMEOUT_CYCLES with done and err together.
        set_req(0, 1'b1, 1'b0, 32'h0000_DEAD, 8'h44);
        step();
        check_eq("to_rd_start", 32'(io_rd), 32'd1);
        n = 0;
        while (io_rd && n < 200) begin step(); n++; end
        check_eq("to_cycles", 32'(n), 32'd100);
        check_eq("to_req_done", 32'(req_done), 32'b001);
        check_eq("to_req_err", 32'(req_err), 32'b001);
        set_req(0, 1'b0, 1'b0, 32'd0, 8'd0);
        m_ptr = 1;
        step();
        check_eq("to_done_end", 32'(req_done), 32'd0);
        check_eq("to_err_end", 32'(req_err), 32'd0);
`else
        // No acknowledge: the request is held indefinitely.
        set_req(0, 1'b1, 1'b0, 32'h0000_DEAD, 8'h44);
        run_txn(0, 1, 1'b0, 1'b0, 10000);
`endif

        // Randomized traffic against the round-robin model.
        for (int t = 0; t < 40; t++) begin
            bit keep, mid;
            for (int i = 0; i < N; i++) begin
                if (!(m_rd[i] || m_wr[i]) && $urandom_range(0, 1) == 1) begin
                    logic rd, wr;
                    rd = 1'($urandom_range(0, 1));
                    wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
                    set_req(i, rd, wr, {8'(i), 24'($urandom)}, 8'($urandom));
                end
            end
            if (next_winner() < 0) begin
                w = $urandom_range(0, N - 1);
                set_req(w, 1'b1, 1'b0, {8'(w), 24'($urandom)}, 8'($urandom));
            end
            w = next_winner();
            keep = ($urandom_range(0, 3) == 0);
            mid  = !keep && ($urandom_range(0, 4) == 0);
            run_txn(w, $urandom_range(0, 6), keep, mid, $urandom_range(0, 5));
        end
        for (int d = 0; d < N && next_winner() >= 0; d++) begin
            run_txn(next_winner(), 1, 1'b0, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
